// File: rtl/constant_fetch_sequencer_if.sv
// Program-fetch bus between the constant fetch sequencer and its memory/decode neighbours.
// Signal names match the original flat port list.
interface constant_fetch_sequencer_if;
  logic [7:0]  MemData;
  logic        stall;
  logic        jump_en;
  logic [15:0] JumpAddr;
  logic [15:0] ProgAddr;
  logic        load_lo;
  logic        load_hi;
  logic [7:0]  Instr;
  logic [1:0]  ConstCount;
  logic        instr_valid;
  logic        busy;

  modport master (
    input  MemData, stall, jump_en, JumpAddr,
    output ProgAddr, load_lo, load_hi, Instr, ConstCount, instr_valid, busy
  );

  modport slave (
    output MemData, stall, jump_en, JumpAddr,
    input  ProgAddr, load_lo, load_hi, Instr, ConstCount, instr_valid, busy
  );
endinterface

// File: rtl/constant_fetch_sequencer.sv
// Walks program memory: captures an opcode, then strobes the low/high constant
// registers for the 0-2 constant bytes that follow it.
module constant_fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  constant_fetch_sequencer_if.master    bus
);

  localparam logic [1:0] ST_FETCH_OP = 2'd0;
  localparam logic [1:0] ST_CONST_LO = 2'd1;
  localparam logic [1:0] ST_CONST_HI = 2'd2;

  logic [15:0] r_pc;
  logic [1:0]  r_state;
  logic [7:0]  r_instr;
  logic [1:0]  r_cnt;
  logic        r_valid;

  logic [1:0]  w_decode;
  logic [1:0]  w_state_nxt;
  logic        w_valid_nxt;

  always_comb begin
    case (bus.MemData[7:6])
      2'b01:   w_decode = 2'd1;
      2'b10:   w_decode = 2'd2;
      default: w_decode = 2'd0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = 1'b0;
    case (r_state)
      ST_FETCH_OP: begin
        if (w_decode != 2'd0) w_state_nxt = ST_CONST_LO;
        else                  w_valid_nxt = 1'b1;
      end
      ST_CONST_LO: begin
        if (r_cnt == 2'd2) begin
          w_state_nxt = ST_CONST_HI;
        end else begin
          w_state_nxt = ST_FETCH_OP;
          w_valid_nxt = 1'b1;
        end
      end
      ST_CONST_HI: begin
        w_state_nxt = ST_FETCH_OP;
        w_valid_nxt = 1'b1;
      end
      default: w_state_nxt = ST_FETCH_OP;
    endcase
  end

  // Jump outranks stall; a stalled edge simply leaves the completing edge for later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_VECTOR;
      r_state <= ST_FETCH_OP;
      r_instr <= 8'h00;
      r_cnt   <= 2'd0;
      r_valid <= 1'b0;
    end else if (bus.jump_en) begin
      r_pc    <= bus.JumpAddr;
      r_state <= ST_FETCH_OP;
      r_valid <= 1'b0;
    end else if (bus.stall) begin
      r_valid <= 1'b0;
    end else begin
      r_pc    <= r_pc + 16'd1;
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      if (r_state == ST_FETCH_OP) begin
        r_instr <= bus.MemData;
        r_cnt   <= w_decode;
      end
    end
  end

  assign bus.ProgAddr    = r_pc;
  assign bus.load_lo     = (r_state == ST_CONST_LO) && !bus.stall && !bus.jump_en;
  assign bus.load_hi     = (r_state == ST_CONST_HI) && !bus.stall && !bus.jump_en;
  assign bus.Instr       = r_instr;
  assign bus.ConstCount  = r_cnt;
  assign bus.instr_valid = r_valid;
  assign bus.busy        = (r_state != ST_FETCH_OP);

endmodule

// File: tb/tb_constant_fetch_sequencer.sv
// Directed and randomized check of constant_fetch_sequencer against a byte-position model.
module tb_constant_fetch_sequencer;

  localparam logic [15:0] RV = 16'h0100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] mem [0:65535];

  int unsigned errors = 0;
  int unsigned checks = 0;

  constant_fetch_sequencer_if bus();

  constant_fetch_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.MemData = mem[bus.ProgAddr];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned nbytes(input logic [7:0] op);
    case (op[7:6])
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 0;
    endcase
  endfunction

  // Model: PC plus position of the current byte within its instruction (0 = opcode).
  logic [15:0] m_pc;
  int unsigned m_pos;
  logic [7:0]  m_instr;
  logic [1:0]  m_cnt;
  logic        m_valid;

  always @(negedge clk) begin
    logic e_lo, e_hi;
    int unsigned total;
    if (!reset_n) begin
      m_pc = RV; m_pos = 0; m_instr = 8'h00; m_cnt = 2'd0; m_valid = 1'b0;
    end
    e_lo = (m_pos == 1) && !bus.stall && !bus.jump_en;
    e_hi = (m_pos == 2) && !bus.stall && !bus.jump_en;
    chk("ProgAddr",    bus.ProgAddr,    m_pc);
    chk("load_lo",     bus.load_lo,     e_lo);
    chk("load_hi",     bus.load_hi,     e_hi);
    chk("busy",        bus.busy,        m_pos != 0);
    chk("Instr",       bus.Instr,       m_instr);
    chk("ConstCount",  bus.ConstCount,  m_cnt);
    chk("instr_valid", bus.instr_valid, m_valid);
    if (reset_n) begin
      if (bus.jump_en) begin
        m_pc = bus.JumpAddr; m_pos = 0; m_valid = 1'b0;
      end else if (bus.stall) begin
        m_valid = 1'b0;
      end else begin
        if (m_pos == 0) begin
          m_instr = mem[m_pc];
          m_cnt   = 2'(nbytes(mem[m_pc]));
        end
        total = m_cnt;
        m_pc  = m_pc + 16'd1;
        if (m_pos == total) begin
          m_pos = 0; m_valid = 1'b1;
        end else begin
          m_pos++; m_valid = 1'b0;
        end
      end
    end
  end

  // Apply inputs just after a rising edge, return at the following falling edge.
  task automatic drive(input logic s, input logic j, input logic [15:0] a);
    @(posedge clk); #1;
    bus.stall = s; bus.jump_en = j; bus.JumpAddr = a;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0100] = 8'h00;
    mem[0] = 8'h80; mem[1] = 8'hAA; mem[2] = 8'h55; mem[3] = 8'h03;
    mem[4] = 8'h40; mem[5] = 8'hFF;
    mem[6] = 8'h40; mem[7] = 8'h11;
    mem[8] = 8'h80; mem[9] = 8'h22; mem[10] = 8'h33;
    mem[16'h2000] = 8'hC0; mem[16'h2001] = 8'h00;
    mem[16'hFFFF] = 8'h80;
    bus.stall = 1'b0; bus.jump_en = 1'b0; bus.JumpAddr = 16'h0000;

    repeat (3) @(negedge clk);
    chk("rst ProgAddr", bus.ProgAddr, 16'h0100);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst valid", bus.instr_valid, 1'b0);
    chk("rst strobes", {bus.load_lo, bus.load_hi}, 2'b00);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);

    drive(1'b0, 1'b1, 16'h0000);
    chk("first fetch", bus.ProgAddr, 16'h0101);
    drive(1'b0, 1'b0, 16'h0000);
    chk("jump target", bus.ProgAddr, 16'h0000);
    drive(1'b0, 1'b0, 16'h0000);
    chk("lo addr", bus.ProgAddr, 16'h0001);
    chk("lo strobe", {bus.load_lo, bus.load_hi, bus.MemData}, {2'b10, 8'hAA});
    drive(1'b0, 1'b0, 16'h0000);
    chk("hi strobe", {bus.load_lo, bus.load_hi, bus.MemData}, {2'b01, 8'h55});
    drive(1'b0, 1'b0, 16'h0000);
    chk("2c done", {bus.instr_valid, bus.Instr, bus.ConstCount}, {1'b1, 8'h80, 2'd2});
    drive(1'b0, 1'b0, 16'h0000);
    chk("0c done", {bus.instr_valid, bus.Instr, bus.ConstCount, bus.load_lo, bus.load_hi},
        {1'b1, 8'h03, 2'd0, 2'b00});
    drive(1'b0, 1'b0, 16'h0000);
    chk("1c lo", {bus.ProgAddr, bus.load_lo, bus.load_hi, bus.instr_valid}, {16'h0005, 3'b100});
    drive(1'b0, 1'b0, 16'h0000);
    chk("1c done", {bus.instr_valid, bus.Instr, bus.ConstCount}, {1'b1, 8'h40, 2'd1});
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 16'h0000);
      chk("stall freeze", {bus.ProgAddr, bus.load_lo}, {16'h0007, 1'b0});
    end
    drive(1'b0, 1'b0, 16'h0000);
    chk("stall release", {bus.ProgAddr, bus.load_lo, bus.instr_valid}, {16'h0007, 2'b10});
    drive(1'b0, 1'b0, 16'h0000);
    chk("stalled done", {bus.instr_valid, bus.Instr, bus.ConstCount}, {1'b1, 8'h40, 2'd1});
    drive(1'b0, 1'b0, 16'h0000);
    chk("pre-jump lo", bus.ProgAddr, 16'h0009);
    drive(1'b1, 1'b1, 16'h2000);
    chk("jump in hi", {bus.ProgAddr, bus.load_hi, bus.busy}, {16'h000A, 2'b01});
    drive(1'b0, 1'b0, 16'h0000);
    chk("after jump", {bus.ProgAddr, bus.busy, bus.instr_valid}, {16'h2000, 2'b00});
    drive(1'b0, 1'b1, 16'hFFFF);
    chk("C0 done", {bus.instr_valid, bus.Instr}, {1'b1, 8'hC0});
    drive(1'b0, 1'b0, 16'h0000);
    chk("wrap op", {bus.ProgAddr, bus.instr_valid}, {16'hFFFF, 1'b0});
    drive(1'b0, 1'b0, 16'h0000);
    chk("wrap lo", {bus.ProgAddr, bus.load_lo}, {16'h0000, 1'b1});
    drive(1'b0, 1'b0, 16'h0000);
    chk("wrap hi", {bus.ProgAddr, bus.load_hi}, {16'h0001, 1'b1});
    drive(1'b0, 1'b0, 16'h0000);
    chk("wrap next", {bus.ProgAddr, bus.instr_valid, bus.Instr}, {16'h0002, 1'b1, 8'h80});

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] tgt;
      tgt = ($urandom_range(3) == 0) ? (16'hFFFE + 16'($urandom_range(1))) : 16'($urandom);
      @(posedge clk); #1;
      reset_n      = ($urandom_range(499) != 0);
      bus.stall    = ($urandom_range(4) == 0);
      bus.jump_en  = ($urandom_range(19) == 0);
      bus.JumpAddr = tgt;
    end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.stall = 1'b0; bus.jump_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
